// File: rtl/mips_pkg.sv
// Shared encodings and types for the write-back destination pipeline.
package mips_pkg;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned LINK_REG = 31;

   typedef enum logic [1:0] {
      REG_DST_RT   = 2'b00,
      REG_DST_RD   = 2'b01,
      REG_DST_LINK = 2'b10,
      REG_DST_NONE = 2'b11
   } reg_dst_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
   } dest_entry_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c + 4'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/mod_dest_stage.sv
// One destination pipeline register: loads every edge, bubble forces an empty entry.
module mod_dest_stage #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bubble_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              we_d_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic              we_q,   we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      we_d   = bubble_i ? 1'b0 : we_i;
      addr_d = bubble_i ? '0   : addr_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
      end
   end

   // Next-state enable is exported so the parent can count post-update writes.
   assign we_d_o = we_d;
   assign we_o   = we_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/mod_wb_dest_pipe.sv
// Destination select at decode, DEPTH-stage carry to write-back, hazard and in-flight reporting.
module mod_wb_dest_pipe #(
   parameter int unsigned ADDR_W       = mips_pkg::ADDR_W,
   parameter int unsigned DEPTH        = 3,
   parameter int unsigned LINK_REG     = mips_pkg::LINK_REG,
   parameter int unsigned FLUSH_STAGES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ins_20_16,
   input  logic [ADDR_W-1:0] ins_15_11,
   input  logic [1:0]        reg_dst,
   input  logic              reg_write,
   input  logic              id_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] src_rs,
   input  logic [ADDR_W-1:0] src_rt,
   output logic [ADDR_W-1:0] write_reg_add,
   output logic              wb_reg_write,
   output logic [DEPTH-1:0]  hazard_rs,
   output logic [DEPTH-1:0]  hazard_rt,
   output logic [3:0]        pending_cnt
);

   import mips_pkg::*;

   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("DEPTH must be in 1..8");
   end
   if (FLUSH_STAGES < 1 || FLUSH_STAGES > DEPTH) begin : g_bad_flush
      $error("FLUSH_STAGES must be in 1..DEPTH");
   end

   reg_dst_e          mode;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;

   logic [DEPTH-1:0]  st_we;
   logic [DEPTH-1:0]  st_we_d;
   logic [DEPTH-1:0]  st_bubble;
   logic [ADDR_W-1:0] st_addr [DEPTH];

   logic [7:0]        we_ext;
   logic [3:0]        pending_d, pending_q;

   assign mode = reg_dst_e'(reg_dst);

   always_comb begin
      sel_addr = '0;
      case (mode)
         REG_DST_RT:   sel_addr = ins_20_16;
         REG_DST_RD:   sel_addr = ins_15_11;
         REG_DST_LINK: sel_addr = ADDR_W'(LINK_REG);
         default:      sel_addr = '0;
      endcase
   end

   assign sel_we = reg_write & id_valid & (mode != REG_DST_NONE) & (sel_addr != '0);

   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
      logic              in_we;
      logic [ADDR_W-1:0] in_addr;

      if (i == 0) begin : g_head
         assign in_we        = sel_we;
         assign in_addr      = sel_addr;
         assign st_bubble[i] = stall | flush;
      end else begin : g_body
         assign in_we   = st_we[i-1];
         assign in_addr = st_addr[i-1];
         // Flush clears the youngest stages after the shift, so it masks what they load.
         if (i < int'(FLUSH_STAGES)) begin : g_fl
            assign st_bubble[i] = flush;
         end else begin : g_nofl
            assign st_bubble[i] = 1'b0;
         end
      end

      mod_dest_stage #(
         .ADDR_W (ADDR_W)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .bubble_i (st_bubble[i]),
         .we_i     (in_we),
         .addr_i   (in_addr),
         .we_d_o   (st_we_d[i]),
         .we_o     (st_we[i]),
         .addr_o   (st_addr[i])
      );
   end

   always_comb begin
      hazard_rs = '0;
      hazard_rt = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hazard_rs[i] = st_we[i] & (st_addr[i] == src_rs) & (src_rs != '0);
         hazard_rt[i] = st_we[i] & (st_addr[i] == src_rt) & (src_rt != '0);
      end
   end

   always_comb begin
      we_ext             = '0;
      we_ext[DEPTH-1:0]  = st_we_d;
      pending_d          = popcount8(we_ext);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign write_reg_add = st_addr[DEPTH-1];
   assign wb_reg_write  = st_we[DEPTH-1];
   assign pending_cnt   = pending_q;

endmodule

// File: tb/tb_mod_wb_dest_pipe.sv
// Scoreboard bench: decode-side pushes expected write-backs, a negedge monitor pops and compares.
module tb_mod_wb_dest_pipe;

   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] ins_20_16, ins_15_11, src_rs, src_rt;
   logic [1:0]    reg_dst;
   logic          reg_write, id_valid, stall, flush;
   logic [AW-1:0] write_reg_add;
   logic          wb_reg_write;
   logic [DEPTH-1:0] hazard_rs, hazard_rt;
   logic [3:0]    pending_cnt;

   typedef struct {
      int unsigned   edge_no;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t        sb[$];
   int unsigned edges = 0;
   int          checks = 0;
   int          failures = 0;

   mod_wb_dest_pipe #(
      .ADDR_W       (AW),
      .DEPTH        (DEPTH),
      .LINK_REG     (31),
      .FLUSH_STAGES (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ins_20_16     (ins_20_16),
      .ins_15_11     (ins_15_11),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .id_valid      (id_valid),
      .stall         (stall),
      .flush         (flush),
      .src_rs        (src_rs),
      .src_rt        (src_rt),
      .write_reg_add (write_reg_add),
      .wb_reg_write  (wb_reg_write),
      .hazard_rs     (hazard_rs),
      .hazard_rt     (hazard_rt),
      .pending_cnt   (pending_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edges);
      end
   endtask

   // Monitor: every presented write-back must match the oldest expectation, on time.
   always @(negedge clk) begin
      if (wb_reg_write === 1'b1) begin
         exp_t e;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb actual=%0d required=none (edge %0d)", write_reg_add, edges);
         end else begin
            e = sb.pop_front();
            chk("wb_addr", 32'(write_reg_add), 32'(e.addr));
            chk("wb_edge", 32'(edges), 32'(e.edge_no));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] dst, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic rw, input logic v);
      reg_dst   = dst;
      ins_20_16 = rt;
      ins_15_11 = rd;
      reg_write = rw;
      id_valid  = v;
   endtask

   task automatic idle();
      drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // Expected write-back for an instruction accepted on the coming edge.
   task automatic push(input logic [AW-1:0] a);
      exp_t e;
      e.edge_no = edges + 1 + DEPTH - 1;
      e.addr    = a;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      src_rs = 5'd7;
      src_rt = 5'd0;
      drive(2'b01, 5'd9, 5'd7, 1'b1, 1'b1);
      step();
      step();
      chk("rst_addr",    32'(write_reg_add), 32'd0);
      chk("rst_we",      32'(wb_reg_write),  32'd0);
      chk("rst_pending", 32'(pending_cnt),   32'd0);
      chk("rst_haz_rs",  32'(hazard_rs),     32'd0);

      // Release with r7 on decode: reaches WB after edge 5.
      rst_n = 1'b1;
      push(5'd7);
      step();
      chk("lat_pend0", 32'(pending_cnt), 32'd1);
      idle();
      step();
      chk("lat_pend1", 32'(pending_cnt), 32'd1);
      step();
      chk("lat_pend2", 32'(pending_cnt), 32'd1);
      step();
      chk("lat_pend3", 32'(pending_cnt), 32'd0);

      // rt, link, none back to back
      drive(2'b00, 5'd9, 5'd7, 1'b1, 1'b1); push(5'd9); step();
      drive(2'b10, 5'd9, 5'd7, 1'b1, 1'b1); push(5'd31); step();
      drive(2'b11, 5'd9, 5'd7, 1'b1, 1'b1); step();
      chk("sel_pend", 32'(pending_cnt), 32'd2);
      idle();
      step(); step(); step();
      chk("sel_drain", 32'(pending_cnt), 32'd0);

      // $0 and invalid-slot suppression
      drive(2'b01, 5'd9, 5'd0, 1'b1, 1'b1); step();
      chk("zero_rd_pend", 32'(pending_cnt), 32'd0);
      src_rs = 5'd0; #1;
      chk("zero_haz_rs", 32'(hazard_rs), 32'd0);
      drive(2'b00, 5'd0, 5'd3, 1'b1, 1'b1); step();
      drive(2'b01, 5'd9, 5'd12, 1'b1, 1'b0); step();
      chk("zero_rt_inval_pend", 32'(pending_cnt), 32'd0);
      idle();
      step(); step(); step();

      // Hazard: two writes to r5
      drive(2'b01, 5'd0, 5'd5, 1'b1, 1'b1); push(5'd5); step();
      push(5'd5); step();
      idle();
      src_rs = 5'd5; src_rt = 5'd6; #1;
      chk("haz_rs_011", 32'(hazard_rs), 32'b011);
      chk("haz_rt_0",   32'(hazard_rt), 32'b000);
      src_rt = 5'd5; #1;
      chk("haz_rt_011", 32'(hazard_rt), 32'b011);
      step();
      chk("haz_rs_110", 32'(hazard_rs), 32'b110);
      step();
      chk("haz_rs_100", 32'(hazard_rs), 32'b100);
      step();
      chk("haz_rs_000", 32'(hazard_rs), 32'b000);
      src_rs = 5'd0; src_rt = 5'd0;

      // Stall holds decode and inserts bubbles
      drive(2'b01, 5'd0, 5'd4, 1'b1, 1'b1); push(5'd4); step();
      chk("stall_pend0", 32'(pending_cnt), 32'd1);
      stall = 1'b1;
      step();
      chk("stall_pend1", 32'(pending_cnt), 32'd1);
      step();
      chk("stall_pend2", 32'(pending_cnt), 32'd1);
      stall = 1'b0;
      idle();
      step();
      chk("stall_pend3", 32'(pending_cnt), 32'd0);

      // Stall with flush on a write: still a bubble
      drive(2'b01, 5'd0, 5'd10, 1'b1, 1'b1);
      stall = 1'b1; flush = 1'b1;
      step();
      stall = 1'b0; flush = 1'b0;
      chk("stall_flush_pend", 32'(pending_cnt), 32'd0);
      idle();
      step(); step(); step();

      // Flush kills r3 only
      drive(2'b01, 5'd0, 5'd1, 1'b1, 1'b1); push(5'd1); step();
      drive(2'b01, 5'd0, 5'd2, 1'b1, 1'b1); push(5'd2); step();
      drive(2'b01, 5'd0, 5'd3, 1'b1, 1'b1); flush = 1'b1; step();
      flush = 1'b0;
      chk("flush_pend2", 32'(pending_cnt), 32'd2);
      idle();
      step();
      chk("flush_pend1", 32'(pending_cnt), 32'd1);
      step();
      chk("flush_pend0", 32'(pending_cnt), 32'd0);

      // Reset mid-flight discards r8
      drive(2'b01, 5'd0, 5'd8, 1'b1, 1'b1); step();
      chk("r8_pend", 32'(pending_cnt), 32'd1);
      idle();
      rst_n = 1'b0;
      step();
      src_rs = 5'd8; #1;
      chk("mid_rst_addr", 32'(write_reg_add), 32'd0);
      chk("mid_rst_we",   32'(wb_reg_write),  32'd0);
      chk("mid_rst_pend", 32'(pending_cnt),   32'd0);
      chk("mid_rst_haz",  32'(hazard_rs),     32'd0);
      rst_n = 1'b1;
      step(); step(); step(); step();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
